seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for a bank of NUM_DIGITS common-cathode or common-anode 7-segment digits that share one segment bus.
- Holds a tear-free snapshot of the packed BCD value and walks the digits one slot at a time.
- Each slot has a ghost-suppression blanking gap before the digit is lit.
- Decoding goes through one shared bcd_to_7seg instance; leading-zero blanking is optional.
- Sits between the numeric datapath (counters, ALU results) and the board display pins.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/bcd_to_7seg.sv | 31 +++
 rtl/seg7_scan_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam int         MAX_DIGITS = 16;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

    function automatic logic [3:0] digit_sel(input logic [4*MAX_DIGITS-1:0] active,
                                             input logic [3:0]              idx);
        return active[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to 7-segment decoder, seg[0]=a .. seg[6]=g; codes above 9 decode to all-off.
// Purely combinational, no flow control.
module bcd_to_7seg #(
    parameter int COMMON_ANODE = 0
) (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = 7'b0000000;
        case (bcd)
            4'd0:    seg_hi = 7'b0111111;
            4'd1:    seg_hi = 7'b0000110;
            4'd2:    seg_hi = 7'b1011011;
            4'd3:    seg_hi = 7'b1001111;
            4'd4:    seg_hi = 7'b1100110;
            4'd5:    seg_hi = 7'b1101101;
            4'd6:    seg_hi = 7'b1111101;
            4'd7:    seg_hi = 7'b0000111;
            4'd8:    seg_hi = 7'b1111111;
            4'd9:    seg_hi = 7'b1101111;
            default: seg_hi = 7'b0000000;
        endcase
    end

    assign seg = (COMMON_ANODE != 0) ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: tear-free frame snapshot, blanking gap per slot, optional leading-zero blanking.
// Latency: outputs registered; first digit lit BLANK_CYCLES+1 clocks after en rises.
// Backpressure: none; load is accepted every clock, last write wins.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    import seg7_pkg::*;

    localparam int              IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              CW        = $clog2(SCAN_DIV);
    localparam logic            INV       = (COMMON_ANODE != 0);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]   SLOT_END  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;
    logic                    boundary;

    logic [4*MAX_DIGITS-1:0] act_ext;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_raw;
    logic [IW-1:0]           lz_m;
    logic                    suppress;
    logic                    show;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        boundary     = 1'b0;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    idx_d    = '0;
                    cnt_d    = '0;
                    boundary = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_END) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == SLOT_END) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d        = '0;
                            boundary     = 1'b1;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // pend_*_d already carries this clock's load, giving the boundary bypass for free
        pend_dig_d = load ? digits_in : pend_dig_q;
        pend_dp_d  = load ? dp_in     : pend_dp_q;
        act_dig_d  = boundary ? pend_dig_d : act_dig_q;
        act_dp_d   = boundary ? pend_dp_d  : act_dp_q;
    end

    always_comb begin
        act_ext                     = '0;
        act_ext[4*NUM_DIGITS-1:0]   = act_dig_d;
        cur_nib                     = digit_sel(act_ext, 4'(idx_d));
    end

    bcd_to_7seg #(
        .COMMON_ANODE (0)
    ) u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

    // Outputs are computed from next-state values so the registered pins line up with the state
    always_comb begin
        lz_m = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act_dig_d[4*i +: 4] != 4'd0 || act_dp_d[i]) lz_m = IW'(i);
        end
        suppress = lz_blank && (idx_d > lz_m);
        seg_raw  = (bcd_valid(cur_nib) && !suppress) ? dec_seg : SEG_BLANK;
        show     = (state_d == SHOW);
        an_d     = (show ? (NUM_DIGITS'(1) << idx_d) : '0) ^ {NUM_DIGITS{INV}};
        seg_d    = (show ? seg_raw : SEG_BLANK) ^ {7{INV}};
        dp_d     = (show & act_dp_d[idx_d]) ^ INV;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            an_q         <= {NUM_DIGITS{INV}};
            seg_q        <= {7{INV}};
            dp_q         <= INV;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
